// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types and saturation constants for the ALU flag stage
package alu_pkg;

  localparam int ALU_WIDTH = 16;

  typedef enum logic [1:0] {
    OP_ARITH = 2'b00,
    OP_LOGIC = 2'b01,
    OP_PASS  = 2'b10
  } op_class_t;

  typedef struct packed {
    logic z;
    logic v;
    logic n;
  } flags_t;

  // Wide helpers; callers truncate to their own WIDTH (valid up to 64 bits).
  function automatic logic [63:0] sat_pos(int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_neg(int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/sat_unit.sv
// rtl/sat_unit.sv - combinational signed saturation of the raw adder sum
module sat_unit
  import alu_pkg::*;
#(
  parameter int WIDTH  = ALU_WIDTH,
  parameter bit SAT_EN = 1'b1
) (
  input  logic [WIDTH-1:0] sum,
  input  logic             ovfl,
  input  logic [1:0]       op_class,
  output logic [WIDTH-1:0] sat_result
);

  localparam logic [WIDTH-1:0] SAT_POS = WIDTH'(sat_pos(WIDTH));
  localparam logic [WIDTH-1:0] SAT_NEG = WIDTH'(sat_neg(WIDTH));

  always_comb begin
    sat_result = sum;
    // A wrapped sum with the sign bit set means the true result overflowed positive.
    if (SAT_EN && ovfl && (op_class == OP_ARITH)) begin
      sat_result = sum[WIDTH-1] ? SAT_POS : SAT_NEG;
    end
  end

endmodule

// File: rtl/alu_flag_stage.sv
// rtl/alu_flag_stage.sv - saturating result register and architectural Z/V/N flags
module alu_flag_stage
  import alu_pkg::*;
#(
  parameter int WIDTH  = ALU_WIDTH,
  parameter bit SAT_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] sum,
  input  logic             ovfl,
  input  logic [1:0]       op_class,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_v,
  output logic             flag_n
);

  logic [WIDTH-1:0] sat_result;
  logic             capture;
  flags_t           flags_q;
  flags_t           flags_d;

  sat_unit #(
    .WIDTH  (WIDTH),
    .SAT_EN (SAT_EN)
  ) u_sat (
    .sum        (sum),
    .ovfl       (ovfl),
    .op_class   (op_class),
    .sat_result (sat_result)
  );

  assign in_ready = !out_valid || out_ready;
  assign capture  = in_valid && in_ready && !flush;

  // Flags come from the pre-saturation sum so branches see the true overflow.
  always_comb begin
    flags_d = flags_q;
    if (op_class == OP_ARITH) begin
      flags_d.z = (sum == '0);
      flags_d.v = ovfl;
      flags_d.n = sum[WIDTH-1];
    end else if (op_class == OP_LOGIC) begin
      flags_d.z = (sum == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      flags_q   <= '0;
    end else begin
      if (capture) begin
        out_valid <= 1'b1;
        result    <= sat_result;
        flags_q   <= flags_d;
      end else if (flush || out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign flag_z = flags_q.z;
  assign flag_v = flags_q.v;
  assign flag_n = flags_q.n;

endmodule

// File: tb/tb_alu_flag_stage.sv
// tb/tb_alu_flag_stage.sv - directed self-checking bench for alu_flag_stage
module tb_alu_flag_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] sum;
  logic        ovfl;
  logic [1:0]  op_class;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        flag_z;
  logic        flag_v;
  logic        flag_n;

  int total = 0;
  int bad   = 0;

  alu_flag_stage #(.WIDTH(16), .SAT_EN(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum       (sum),
    .ovfl      (ovfl),
    .op_class  (op_class),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flag_z    (flag_z),
    .flag_v    (flag_v),
    .flag_n    (flag_n)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] oc, input logic [15:0] s, input logic ov);
    in_valid = 1'b1;
    op_class = oc;
    sum      = s;
    ovfl     = ov;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive(2'b00, 16'h5555, 1'b1);
    step();
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    total++; if (result !== 16'h0000) begin bad++; $display("FAIL reset_result got=%h exp=0000", result); end
    total++; if ({flag_z, flag_v, flag_n} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {flag_z, flag_v, flag_n}); end
    rst = 1'b0; in_valid = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_zero();
    drive(2'b00, 16'h0000, 1'b0);
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL zero_valid got=%b exp=1", out_valid); end
    total++; if (result !== 16'h0000) begin bad++; $display("FAIL zero_result got=%h exp=0000", result); end
    total++; if ({flag_z, flag_v, flag_n} !== 3'b100) begin bad++; $display("FAIL zero_flags got=%b exp=100", {flag_z, flag_v, flag_n}); end
  endtask

  task automatic test_saturate();
    drive(2'b00, 16'h8001, 1'b1);
    step();
    total++; if (result !== 16'h7FFF) begin bad++; $display("FAIL sat_pos_result got=%h exp=7fff", result); end
    total++; if ({flag_z, flag_v, flag_n} !== 3'b011) begin bad++; $display("FAIL sat_pos_flags got=%b exp=011", {flag_z, flag_v, flag_n}); end
    drive(2'b00, 16'h7FFF, 1'b1);
    step();
    total++; if (result !== 16'h8000) begin bad++; $display("FAIL sat_neg_result got=%h exp=8000", result); end
    total++; if ({flag_z, flag_v, flag_n} !== 3'b010) begin bad++; $display("FAIL sat_neg_flags got=%b exp=010", {flag_z, flag_v, flag_n}); end
    in_valid = 1'b0;
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL drain_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_stall();
    out_ready = 1'b1;
    drive(2'b00, 16'h0042, 1'b0);
    step();
    out_ready = 1'b0;
    drive(2'b00, 16'h1234, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready cyc=%0d got=%b exp=0", i, in_ready); end
      step();
      total++; if (result !== 16'h0042 || out_valid !== 1'b1) begin bad++; $display("FAIL stall_hold cyc=%0d got=%h/%b exp=0042/1", i, result, out_valid); end
      total++; if ({flag_z, flag_v, flag_n} !== 3'b000) begin bad++; $display("FAIL stall_flags cyc=%0d got=%b exp=000", i, {flag_z, flag_v, flag_n}); end
    end
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL unstall_in_ready got=%b exp=1", in_ready); end
    step();
    in_valid = 1'b0;
    total++; if (result !== 16'h1234 || out_valid !== 1'b1) begin bad++; $display("FAIL unstall_capture got=%h/%b exp=1234/1", result, out_valid); end
  endtask

  task automatic test_flush();
    drive(2'b00, 16'h0000, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b exp=0", out_valid); end
    total++; if (flag_z !== 1'b0) begin bad++; $display("FAIL flush_z got=%b exp=0", flag_z); end
    total++; if (result !== 16'h1234) begin bad++; $display("FAIL flush_result got=%h exp=1234", result); end
    drive(2'b00, 16'h00FF, 1'b0);
    step();
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0; out_ready = 1'b1;
    total++; if (out_valid !== 1'b0 || result !== 16'h00FF) begin bad++; $display("FAIL flush_stall got=%b/%h exp=0/00ff", out_valid, result); end
  endtask

  task automatic test_logic_pass();
    drive(2'b00, 16'h8001, 1'b1);
    step();
    drive(2'b01, 16'h0000, 1'b0);
    step();
    total++; if (result !== 16'h0000) begin bad++; $display("FAIL logic_result got=%h exp=0000", result); end
    total++; if ({flag_z, flag_v, flag_n} !== 3'b111) begin bad++; $display("FAIL logic_flags got=%b exp=111", {flag_z, flag_v, flag_n}); end
    drive(2'b01, 16'h8000, 1'b1);
    step();
    total++; if (result !== 16'h8000) begin bad++; $display("FAIL logic_nosat got=%h exp=8000", result); end
    total++; if ({flag_z, flag_v, flag_n} !== 3'b011) begin bad++; $display("FAIL logic_flags2 got=%b exp=011", {flag_z, flag_v, flag_n}); end
    drive(2'b10, 16'h0000, 1'b0);
    step();
    total++; if (result !== 16'h0000 || {flag_z, flag_v, flag_n} !== 3'b011) begin bad++; $display("FAIL pass got=%h/%b exp=0000/011", result, {flag_z, flag_v, flag_n}); end
    drive(2'b11, 16'hFFFF, 1'b1);
    step();
    in_valid = 1'b0;
    total++; if (result !== 16'hFFFF || {flag_z, flag_v, flag_n} !== 3'b011) begin bad++; $display("FAIL reserved got=%h/%b exp=ffff/011", result, {flag_z, flag_v, flag_n}); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] sv [3];
    logic        ov [3];
    logic [15:0] er [3];
    logic [2:0]  ef [3];
    sv = '{16'h0001, 16'hFFFF, 16'h8000};
    ov = '{1'b0, 1'b0, 1'b1};
    er = '{16'h0001, 16'hFFFF, 16'h7FFF};
    ef = '{3'b000, 3'b001, 3'b011};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(2'b00, sv[i], ov[i]);
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready idx=%0d got=%b exp=1", i, in_ready); end
      step();
      total++; if (result !== er[i] || out_valid !== 1'b1) begin bad++; $display("FAIL b2b_result idx=%0d got=%h/%b exp=%h/1", i, result, out_valid, er[i]); end
      total++; if ({flag_z, flag_v, flag_n} !== ef[i]) begin bad++; $display("FAIL b2b_flags idx=%0d got=%b exp=%b", i, {flag_z, flag_v, flag_n}, ef[i]); end
    end
    in_valid = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; sum = '0; ovfl = 1'b0; op_class = 2'b00;
    flush = 1'b0; out_ready = 1'b1;
    #1;
    test_reset();
    test_zero();
    test_saturate();
    test_stall();
    test_flush();
    test_logic_pass();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
